// File: rtl/pattern.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | pattern : raster test-pattern source (solid/bars/ramp/checker), 2 px/word,
// |           behind a show-ahead FIFO read port.            Rev 1.0
// +-----------------------------------------------------------------------------
module pattern #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          enable,
   input  logic [CW-1:0] hact,
   input  logic [CW-1:0] vact,
   input  logic [1:0]    mode,
   input  logic [23:0]   colour,
   input  logic          rden,
   output logic          empty,
   output logic [47:0]   dout,
   output logic          sof,
   output logic          eol,
   output logic [7:0]    frame
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wx_q, wx_d;
   logic [CW-1:0] y_q, y_d;
   logic [CW-1:0] hw_q, hw_d;
   logic [CW-1:0] vact_q, vact_d;
   logic [1:0]    mode_q, mode_d;
   logic [23:0]   colour_q, colour_d;
   logic [7:0]    frame_q, frame_d;
   logic          empty_q, empty_d;
   logic          sof_q, sof_d;
   logic          eol_q, eol_d;
   logic [47:0]   dout_q, dout_d;

   logic [CW-1:0] hw_in;
   logic          legal_in;
   logic          last_wx;
   logic          last_y;
   logic          unused_hact0;

   // Pixel colour for column p (low 9 bits suffice for every pattern) on line yy.
   function automatic logic [23:0] pix(input logic [1:0]  m,
                                       input logic [23:0] c,
                                       input logic [8:0]  p,
                                       input logic [7:0]  yy,
                                       input logic [7:0]  f);
      logic [23:0] px;
      px = 24'h0;
      case (m)
         2'd0:    px = c;
         2'd1:    px = {{8{~p[7]}}, {8{~p[8]}}, {8{~p[6]}}};
         2'd2:    px = {p[7:0], yy, f};
         default: px = (p[5] ^ yy[5]) ? c : 24'h0;
      endcase
      return px;
   endfunction

   assign hw_in        = {1'b0, hact[CW-1:1]};
   assign unused_hact0 = hact[0];
   assign legal_in     = (hw_in != '0) && (vact != '0);
   assign last_wx      = (wx_q == hw_q - CW'(1));
   assign last_y       = (y_q == vact_q - CW'(1));

   always_comb begin
      state_d  = state_q;
      wx_d     = wx_q;
      y_d      = y_q;
      hw_d     = hw_q;
      vact_d   = vact_q;
      mode_d   = mode_q;
      colour_d = colour_q;
      frame_d  = frame_q;

      case (state_q)
         S_IDLE: begin
            if (enable && legal_in) begin
               state_d  = S_RUN;
               wx_d     = '0;
               y_d      = '0;
               hw_d     = hw_in;
               vact_d   = vact;
               mode_d   = mode;
               colour_d = colour;
            end
         end
         S_RUN: begin
            if (rden) begin
               if (last_wx) begin
                  wx_d = '0;
                  if (last_y) begin
                     // Frame boundary: the only point where settings are re-sampled.
                     y_d      = '0;
                     frame_d  = frame_q + 8'd1;
                     hw_d     = hw_in;
                     vact_d   = vact;
                     mode_d   = mode;
                     colour_d = colour;
                     state_d  = (enable && legal_in) ? S_RUN : S_IDLE;
                  end else begin
                     y_d = y_q + CW'(1);
                  end
               end else begin
                  wx_d = wx_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next-state view so dout tracks (wx,y) with no bubble.
      empty_d = (state_d != S_RUN);
      sof_d   = (state_d == S_RUN) && (wx_d == '0) && (y_d == '0);
      eol_d   = (state_d == S_RUN) && (wx_d == hw_d - CW'(1));
      dout_d  = 48'h0;
      if (state_d == S_RUN) begin
         dout_d = {pix(mode_d, colour_d, {wx_d[7:0], 1'b0}, y_d[7:0], frame_d),
                   pix(mode_d, colour_d, {wx_d[7:0], 1'b1}, y_d[7:0], frame_d)};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         wx_q     <= '0;
         y_q      <= '0;
         hw_q     <= '0;
         vact_q   <= '0;
         mode_q   <= 2'd0;
         colour_q <= 24'h0;
         frame_q  <= 8'd0;
         empty_q  <= 1'b1;
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
         dout_q   <= 48'h0;
      end else begin
         state_q  <= state_d;
         wx_q     <= wx_d;
         y_q      <= y_d;
         hw_q     <= hw_d;
         vact_q   <= vact_d;
         mode_q   <= mode_d;
         colour_q <= colour_d;
         frame_q  <= frame_d;
         empty_q  <= empty_d;
         sof_q    <= sof_d;
         eol_q    <= eol_d;
         dout_q   <= dout_d;
      end
   end

   assign empty = empty_q;
   assign dout  = dout_q;
   assign sof   = sof_q;
   assign eol   = eol_q;
   assign frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_pattern : directed vector bench for the pattern source.   Rev 1.0
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pattern;

   localparam int CW = 16;

   logic          clk    = 1'b0;
   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic [CW-1:0] hact   = '0;
   logic [CW-1:0] vact   = '0;
   logic [1:0]    mode   = 2'd0;
   logic [23:0]   colour = 24'h0;
   logic          rden   = 1'b0;
   logic          empty;
   logic [47:0]   dout;
   logic          sof;
   logic          eol;
   logic [7:0]    frame;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pattern #(.CW(CW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .enable (enable),
      .hact   (hact),
      .vact   (vact),
      .mode   (mode),
      .colour (colour),
      .rden   (rden),
      .empty  (empty),
      .dout   (dout),
      .sof    (sof),
      .eol    (eol),
      .frame  (frame)
   );

   // One record: expected outputs at this sample, then inputs driven for the next edge.
   typedef struct {
      logic        rd;
      logic        en;
      logic [23:0] col;
      logic        ex_empty;
      logic [47:0] ex_dout;
      logic        ex_sof;
      logic        ex_eol;
      logic [7:0]  ex_frame;
   } vec_t;

   vec_t tbl[$];

   function automatic void push(input logic rd, input logic en, input logic [23:0] col,
                                input logic e, input logic [47:0] d, input logic s,
                                input logic l, input logic [7:0] f);
      vec_t v;
      v.rd = rd; v.en = en; v.col = col;
      v.ex_empty = e; v.ex_dout = d; v.ex_sof = s; v.ex_eol = l; v.ex_frame = f;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic e, input logic [47:0] d,
                          input logic s, input logic l, input logic [7:0] f);
      chk({name, ".empty"}, 64'(empty), 64'(e));
      chk({name, ".dout"},  64'(dout),  64'(d));
      chk({name, ".sof"},   64'(sof),   64'(s));
      chk({name, ".eol"},   64'(eol),   64'(l));
      chk({name, ".frame"}, 64'(frame), 64'(f));
   endtask

   task automatic run_table(input string name);
      foreach (tbl[i]) begin
         @(negedge clk);
         chk_all($sformatf("%s[%0d]", name, i), tbl[i].ex_empty, tbl[i].ex_dout,
                 tbl[i].ex_sof, tbl[i].ex_eol, tbl[i].ex_frame);
         rden   = tbl[i].rd;
         enable = tbl[i].en;
         colour = tbl[i].col;
      end
      tbl.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      enable = 1'b0;
      rden   = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic setup(input int h, input int v, input logic [1:0] m,
                        input logic [23:0] c, input logic rd);
      hact   = CW'(h);
      vact   = CW'(v);
      mode   = m;
      colour = c;
      rden   = rd;
      enable = 1'b1;
   endtask

   localparam logic [47:0] SOLID = 48'hCCAAFF_CCAAFF;
   localparam logic [47:0] DROPW = 48'h123456_123456;
   localparam logic [47:0] CHKW  = 48'h0A0B0C_0A0B0C;

   initial begin
      // Reset and idle with illegal geometry
      repeat (2) @(negedge clk);
      chk_all("reset", 1'b1, 48'h0, 1'b0, 1'b0, 8'h00);
      resetn = 1'b1;
      setup(1, 2, 2'd0, 24'hFFFFFF, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("idle_hact1[%0d].empty", i), 64'(empty), 64'd1);
      end
      hact = CW'(4);
      vact = CW'(0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("idle_vact0[%0d].empty", i), 64'(empty), 64'd1);
      end

      // Solid 4x2 walk, continuous reads
      do_reset();
      setup(4, 2, 2'd0, 24'hCCAAFF, 1'b1);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 1, 0, 8'd0);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 0, 1, 8'd0);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 0, 0, 8'd0);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 0, 1, 8'd0);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 1, 0, 8'd1);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 0, 1, 8'd1);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 0, 0, 8'd1);
      push(1, 1, 24'hCCAAFF, 0, SOLID, 0, 1, 8'd1);
      run_table("solid");

      // Ramp 8x2 with reads on alternate cycles
      do_reset();
      setup(8, 2, 2'd2, 24'h0, 1'b0);
      push(1, 1, 24'h0, 0, 48'h000000_010000, 1, 0, 8'd0);
      push(0, 1, 24'h0, 0, 48'h020000_030000, 0, 0, 8'd0);
      push(1, 1, 24'h0, 0, 48'h020000_030000, 0, 0, 8'd0);
      push(0, 1, 24'h0, 0, 48'h040000_050000, 0, 0, 8'd0);
      push(1, 1, 24'h0, 0, 48'h040000_050000, 0, 0, 8'd0);
      push(0, 1, 24'h0, 0, 48'h060000_070000, 0, 1, 8'd0);
      push(1, 1, 24'h0, 0, 48'h060000_070000, 0, 1, 8'd0);
      push(0, 1, 24'h0, 0, 48'h000100_010100, 0, 0, 8'd0);
      push(1, 1, 24'h0, 0, 48'h000100_010100, 0, 0, 8'd0);
      push(0, 1, 24'h0, 0, 48'h020100_030100, 0, 0, 8'd0);
      push(1, 1, 24'h0, 0, 48'h020100_030100, 0, 0, 8'd0);
      push(0, 1, 24'h0, 0, 48'h040100_050100, 0, 0, 8'd0);
      push(1, 1, 24'h0, 0, 48'h040100_050100, 0, 0, 8'd0);
      push(0, 1, 24'h0, 0, 48'h060100_070100, 0, 1, 8'd0);
      push(1, 1, 24'h0, 0, 48'h060100_070100, 0, 1, 8'd0);
      push(0, 1, 24'h0, 0, 48'h000001_010001, 1, 0, 8'd1);
      run_table("ramp");

      // Enable dropped (and colour changed) mid line 0 of an 8x2 frame
      do_reset();
      setup(8, 2, 2'd0, 24'h123456, 1'b1);
      push(1, 1, 24'h123456, 0, DROPW, 1, 0, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 0, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 0, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 1, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 0, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 0, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 0, 8'd0);
      push(1, 0, 24'h654321, 0, DROPW, 0, 1, 8'd0);
      push(1, 0, 24'h654321, 1, 48'h0, 0, 0, 8'd1);
      push(1, 0, 24'h654321, 1, 48'h0, 0, 0, 8'd1);
      run_table("drop");

      // Colour bars on a 1024-pixel line
      do_reset();
      setup(1024, 1, 2'd1, 24'h0, 1'b1);
      for (int k = 0; k <= 224; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("bars[0].dout", 64'(dout), 64'(48'hFFFFFF_FFFFFF));
            chk("bars[0].sof",  64'(sof),  64'd1);
         end
         if (k == 32)  chk("bars[32].dout",  64'(dout), 64'(48'hFFFF00_FFFF00));
         if (k == 96)  chk("bars[96].dout",  64'(dout), 64'(48'h00FF00_00FF00));
         if (k == 224) chk("bars[224].dout", 64'(dout), 64'(48'h000000_000000));
      end

      // Checkerboard: 32-pixel squares, 64 words x 40 lines
      do_reset();
      setup(128, 40, 2'd3, 24'h0A0B0C, 1'b1);
      for (int n = 0; n < 32 * 64 + 17; n++) begin
         @(negedge clk);
         if (n == 15)          chk("chk(15,0)",  64'(dout), 64'(48'h0));
         if (n == 16)          chk("chk(16,0)",  64'(dout), 64'(CHKW));
         if (n == 32 * 64)     chk("chk(0,32)",  64'(dout), 64'(CHKW));
         if (n == 32 * 64 + 16) chk("chk(16,32)", 64'(dout), 64'(48'h0));
      end

      // One word per frame: sof/eol together, frame wraps, ramp blue follows frame
      do_reset();
      setup(2, 1, 2'd2, 24'h0, 1'b1);
      for (int k = 0; k <= 256; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("wrap[0].sof", 64'(sof), 64'd1);
            chk("wrap[0].eol", 64'(eol), 64'd1);
         end
         if (k == 1)   chk("wrap[1].dout",   64'(dout),  64'(48'h000001_010001));
         if (k == 255) chk("wrap[255].dout", 64'(dout),  64'(48'h0000FF_0100FF));
         if (k == 256) begin
            chk("wrap[256].frame", 64'(frame), 64'd0);
            chk("wrap[256].dout",  64'(dout),  64'(48'h000000_010000));
            chk("wrap[256].sofeol", 64'({sof, eol}), 64'd3);
         end
      end

      // Asynchronous reset while parked at (1,1) of the second frame
      do_reset();
      setup(4, 2, 2'd0, 24'hCCAAFF, 1'b1);
      repeat (8) @(negedge clk);
      chk_all("mid(1,1)", 1'b0, SOLID, 1'b0, 1'b1, 8'd1);
      rden = 1'b0;
      @(negedge clk);
      chk_all("hold(1,1)", 1'b0, SOLID, 1'b0, 1'b1, 8'd1);
      #2 resetn = 1'b0;
      #1 chk_all("async_rst", 1'b1, 48'h0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk_all("after_rst", 1'b0, SOLID, 1'b1, 1'b0, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
